// File: rtl/icache_if.sv
// Fetcher <-> icache <-> memory-controller signal bundle.
// slave is the cache's view; master is the environment driving requests and completions.
interface icache_if;
  logic        ena;
  logic        in_rollback;
  logic        in_pc_ena;
  logic [31:0] in_pc_addr;
  logic        out_inst_ok;
  logic [31:0] out_inst;
  logic        out_mem_ena;
  logic [31:0] out_mem_addr;
  logic        in_mem_ok;
  logic [31:0] in_mem_data;

  modport slave (
    input  ena, in_rollback, in_pc_ena, in_pc_addr, in_mem_ok, in_mem_data,
    output out_inst_ok, out_inst, out_mem_ena, out_mem_addr
  );

  modport master (
    output ena, in_rollback, in_pc_ena, in_pc_addr, in_mem_ok, in_mem_data,
    input  out_inst_ok, out_inst, out_mem_ena, out_mem_addr
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped one-word-per-line icache: hits answer next cycle, misses issue one fetch pulse
// and complete the cycle after in_mem_ok; rollback drops the outstanding fetch.
module icache #(
  parameter int INDEX_BITS = 8
) (
  input logic        clk,
  input logic        rst,
  icache_if.slave    bus
);
  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = 32 - INDEX_BITS - 2;

  typedef enum logic {IDLE, MISS} state_t;

  state_t                state;
  logic [LINES-1:0]      valid;
  logic [TAG_BITS-1:0]   tag_mem  [LINES];
  logic [31:0]           data_mem [LINES];
  logic [31:0]           pend_addr;

  logic                  inst_ok;
  logic [31:0]           inst;
  logic                  mem_ena;
  logic [31:0]           mem_addr;

  logic [INDEX_BITS-1:0] req_idx;
  logic [TAG_BITS-1:0]   req_tag;
  logic [INDEX_BITS-1:0] pend_idx;
  logic [TAG_BITS-1:0]   pend_tag;
  logic                  hit;
  logic                  fill;
  logic                  accept;

  assign req_idx  = bus.in_pc_addr[INDEX_BITS+1:2];
  assign req_tag  = bus.in_pc_addr[31:INDEX_BITS+2];
  assign pend_idx = pend_addr[INDEX_BITS+1:2];
  assign pend_tag = pend_addr[31:INDEX_BITS+2];
  assign hit      = valid[req_idx] && (tag_mem[req_idx] == req_tag);
  // A completion in MISS always fills, even under rollback or with ena low.
  assign fill     = (state == MISS) && bus.in_mem_ok;
  assign accept   = (state == IDLE) && bus.ena && bus.in_pc_ena && !bus.in_rollback;

  always_ff @(posedge clk) begin
    if (fill) begin
      tag_mem[pend_idx]  <= pend_tag;
      data_mem[pend_idx] <= bus.in_mem_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      valid     <= '0;
      pend_addr <= '0;
      inst_ok   <= 1'b0;
      inst      <= '0;
      mem_ena   <= 1'b0;
      mem_addr  <= '0;
    end else begin
      inst_ok <= 1'b0;
      mem_ena <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (hit) begin
              inst    <= data_mem[req_idx];
              inst_ok <= 1'b1;
            end else begin
              mem_addr  <= {bus.in_pc_addr[31:2], 2'b00};
              mem_ena   <= 1'b1;
              pend_addr <= {bus.in_pc_addr[31:2], 2'b00};
              state     <= MISS;
            end
          end
        end
        MISS: begin
          if (bus.in_mem_ok) begin
            valid[pend_idx] <= 1'b1;
            state           <= IDLE;
            if (!bus.in_rollback) begin
              inst    <= bus.in_mem_data;
              inst_ok <= 1'b1;
            end
          end else if (bus.in_rollback) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.out_inst_ok  = inst_ok;
  assign bus.out_inst     = inst;
  assign bus.out_mem_ena  = mem_ena;
  assign bus.out_mem_addr = mem_addr;
endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: miss/fill, hits, conflicts, rollback, ena gating and reset.
module tb_icache;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   asserts = 0;
  int   fails   = 0;

  icache_if bus ();

  icache #(.INDEX_BITS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_pc_ena   = 1'b0;
    bus.in_mem_ok   = 1'b0;
    bus.in_rollback = 1'b0;
    bus.in_mem_data = 32'h0;
  endtask

  task automatic test_reset();
    bus.ena = 1'b1; bus.in_pc_addr = 32'h0;
    idle_inputs();
    rst = 1'b0;
    tick(); tick();
    asserts++; if (bus.out_inst_ok !== 1'b0) begin fails++; $display("FAIL reset_ok got %0h exp 0", bus.out_inst_ok); end
    asserts++; if (bus.out_mem_ena !== 1'b0) begin fails++; $display("FAIL reset_mem_ena got %0h exp 0", bus.out_mem_ena); end
    asserts++; if (bus.out_inst !== 32'h0) begin fails++; $display("FAIL reset_inst got %h exp 0", bus.out_inst); end
    asserts++; if (bus.out_mem_addr !== 32'h0) begin fails++; $display("FAIL reset_mem_addr got %h exp 0", bus.out_mem_addr); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_cold_miss();
    bus.in_pc_ena = 1'b1; bus.in_pc_addr = 32'h0000_0010;
    tick();
    bus.in_pc_ena = 1'b0;
    asserts++; if (bus.out_mem_ena !== 1'b1) begin fails++; $display("FAIL cold_mem_ena got %0h exp 1", bus.out_mem_ena); end
    asserts++; if (bus.out_mem_addr !== 32'h10) begin fails++; $display("FAIL cold_mem_addr got %h exp 00000010", bus.out_mem_addr); end
    asserts++; if (bus.out_inst_ok !== 1'b0) begin fails++; $display("FAIL cold_early_ok got %0h exp 0", bus.out_inst_ok); end
    tick();
    asserts++; if (bus.out_mem_ena !== 1'b0) begin fails++; $display("FAIL cold_mem_ena_pulse got %0h exp 0", bus.out_mem_ena); end
    tick();
    bus.in_mem_ok = 1'b1; bus.in_mem_data = 32'h00A0_0093;
    tick();
    bus.in_mem_ok = 1'b0; bus.in_mem_data = 32'h0;
    asserts++; if (bus.out_inst_ok !== 1'b1) begin fails++; $display("FAIL cold_fill_ok got %0h exp 1", bus.out_inst_ok); end
    asserts++; if (bus.out_inst !== 32'h00A0_0093) begin fails++; $display("FAIL cold_fill_inst got %h exp 00a00093", bus.out_inst); end
    tick();
    asserts++; if (bus.out_inst_ok !== 1'b0) begin fails++; $display("FAIL cold_ok_pulse got %0h exp 0", bus.out_inst_ok); end
  endtask

  task automatic test_back_to_back();
    bus.in_pc_ena = 1'b1; bus.in_pc_addr = 32'h0000_0010;
    tick();
    asserts++; if (bus.out_inst_ok !== 1'b1) begin fails++; $display("FAIL hit_ok got %0h exp 1", bus.out_inst_ok); end
    asserts++; if (bus.out_inst !== 32'h00A0_0093) begin fails++; $display("FAIL hit_inst got %h exp 00a00093", bus.out_inst); end
    asserts++; if (bus.out_mem_ena !== 1'b0) begin fails++; $display("FAIL hit_mem_ena got %0h exp 0", bus.out_mem_ena); end
    bus.in_pc_addr = 32'h0000_0013;
    tick();
    bus.in_pc_ena = 1'b0;
    asserts++; if (bus.out_inst_ok !== 1'b1) begin fails++; $display("FAIL b2b_ok got %0h exp 1", bus.out_inst_ok); end
    asserts++; if (bus.out_inst !== 32'h00A0_0093) begin fails++; $display("FAIL b2b_inst got %h exp 00a00093", bus.out_inst); end
    tick();
  endtask

  task automatic test_conflict();
    bus.in_pc_ena = 1'b1; bus.in_pc_addr = 32'h0000_0410;
    tick();
    bus.in_pc_ena = 1'b0;
    asserts++; if (bus.out_mem_ena !== 1'b1) begin fails++; $display("FAIL conflict_miss got %0h exp 1", bus.out_mem_ena); end
    asserts++; if (bus.out_mem_addr !== 32'h410) begin fails++; $display("FAIL conflict_addr got %h exp 00000410", bus.out_mem_addr); end
    bus.in_mem_ok = 1'b1; bus.in_mem_data = 32'hDEAD_BEEF;
    tick();
    bus.in_mem_ok = 1'b0;
    asserts++; if (bus.out_inst !== 32'hDEAD_BEEF) begin fails++; $display("FAIL conflict_fill got %h exp deadbeef", bus.out_inst); end
    bus.in_pc_ena = 1'b1; bus.in_pc_addr = 32'h0000_0010;
    tick();
    bus.in_pc_ena = 1'b0;
    asserts++; if (bus.out_mem_ena !== 1'b1) begin fails++; $display("FAIL conflict_evicted got %0h exp 1", bus.out_mem_ena); end
    asserts++; if (bus.out_inst_ok !== 1'b0) begin fails++; $display("FAIL conflict_no_hit got %0h exp 0", bus.out_inst_ok); end
    // request held during the completion cycle must be ignored
    bus.in_pc_ena = 1'b1; bus.in_mem_ok = 1'b1; bus.in_mem_data = 32'h00A0_0093;
    tick();
    bus.in_pc_ena = 1'b0; bus.in_mem_ok = 1'b0;
    asserts++; if (bus.out_inst_ok !== 1'b1) begin fails++; $display("FAIL refill_ok got %0h exp 1", bus.out_inst_ok); end
    tick();
    asserts++; if (bus.out_inst_ok !== 1'b0 || bus.out_mem_ena !== 1'b0) begin fails++; $display("FAIL ignored_req got ok=%0h mem=%0h exp 0 0", bus.out_inst_ok, bus.out_mem_ena); end
  endtask

  task automatic test_rollback_miss();
    bus.in_pc_ena = 1'b1; bus.in_pc_addr = 32'h0000_0020;
    tick();
    bus.in_pc_ena = 1'b0;
    tick();
    bus.in_rollback = 1'b1;
    tick();
    bus.in_rollback = 1'b0;
    asserts++; if (bus.out_inst_ok !== 1'b0) begin fails++; $display("FAIL rb_miss_ok got %0h exp 0", bus.out_inst_ok); end
    bus.in_mem_ok = 1'b1; bus.in_mem_data = 32'h5555_5555;
    tick();
    bus.in_mem_ok = 1'b0;
    asserts++; if (bus.out_inst_ok !== 1'b0) begin fails++; $display("FAIL stray_mem_ok got %0h exp 0", bus.out_inst_ok); end
    bus.in_pc_ena = 1'b1;
    tick();
    bus.in_pc_ena = 1'b0;
    asserts++; if (bus.out_mem_ena !== 1'b1) begin fails++; $display("FAIL rb_remiss got %0h exp 1", bus.out_mem_ena); end
    bus.in_mem_ok = 1'b1; bus.in_mem_data = 32'h2222_2222;
    tick();
    bus.in_mem_ok = 1'b0;
    asserts++; if (bus.out_inst !== 32'h2222_2222) begin fails++; $display("FAIL rb_refill got %h exp 22222222", bus.out_inst); end
  endtask

  task automatic test_rollback_fill();
    bus.in_pc_ena = 1'b1; bus.in_pc_addr = 32'h0000_0030;
    tick();
    bus.in_pc_ena = 1'b0;
    tick();
    bus.in_rollback = 1'b1; bus.in_mem_ok = 1'b1; bus.in_mem_data = 32'h1234_5678;
    tick();
    idle_inputs();
    asserts++; if (bus.out_inst_ok !== 1'b0) begin fails++; $display("FAIL rb_fill_ok got %0h exp 0", bus.out_inst_ok); end
    tick();
    bus.in_pc_ena = 1'b1;
    tick();
    bus.in_pc_ena = 1'b0;
    asserts++; if (bus.out_inst_ok !== 1'b1 || bus.out_mem_ena !== 1'b0) begin fails++; $display("FAIL rb_fill_hit got ok=%0h mem=%0h exp 1 0", bus.out_inst_ok, bus.out_mem_ena); end
    asserts++; if (bus.out_inst !== 32'h1234_5678) begin fails++; $display("FAIL rb_fill_data got %h exp 12345678", bus.out_inst); end
    // rollback in the cycle out_mem_ena is high, and a request discarded under rollback
    bus.in_pc_ena = 1'b1; bus.in_pc_addr = 32'h0000_0040;
    tick();
    bus.in_pc_ena = 1'b0; bus.in_rollback = 1'b1;
    tick();
    bus.in_pc_ena = 1'b1; bus.in_pc_addr = 32'h0000_0010;
    tick();
    bus.in_pc_ena = 1'b0; bus.in_rollback = 1'b0;
    asserts++; if (bus.out_inst_ok !== 1'b0) begin fails++; $display("FAIL rb_discard_req got %0h exp 0", bus.out_inst_ok); end
    bus.in_pc_ena = 1'b1; bus.in_pc_addr = 32'h0000_0040;
    tick();
    bus.in_pc_ena = 1'b0;
    asserts++; if (bus.out_mem_ena !== 1'b1) begin fails++; $display("FAIL rb_dropped_fetch got %0h exp 1", bus.out_mem_ena); end
    bus.in_mem_ok = 1'b1; bus.in_mem_data = 32'h4444_4444;
    tick();
    bus.in_mem_ok = 1'b0;
  endtask

  task automatic test_ena();
    bus.ena = 1'b0; bus.in_pc_ena = 1'b1; bus.in_pc_addr = 32'h0000_0010;
    tick();
    bus.in_pc_ena = 1'b0;
    asserts++; if (bus.out_inst_ok !== 1'b0 || bus.out_mem_ena !== 1'b0) begin fails++; $display("FAIL ena_low_req got ok=%0h mem=%0h exp 0 0", bus.out_inst_ok, bus.out_mem_ena); end
    bus.ena = 1'b1; bus.in_pc_ena = 1'b1; bus.in_pc_addr = 32'h0000_0050;
    tick();
    bus.in_pc_ena = 1'b0; bus.ena = 1'b0;
    asserts++; if (bus.out_mem_ena !== 1'b1) begin fails++; $display("FAIL ena_miss got %0h exp 1", bus.out_mem_ena); end
    bus.in_mem_ok = 1'b1; bus.in_mem_data = 32'h5050_5050;
    tick();
    bus.in_mem_ok = 1'b0; bus.ena = 1'b1;
    asserts++; if (bus.out_inst_ok !== 1'b1) begin fails++; $display("FAIL ena_low_fill_ok got %0h exp 1", bus.out_inst_ok); end
    asserts++; if (bus.out_inst !== 32'h5050_5050) begin fails++; $display("FAIL ena_low_fill_inst got %h exp 50505050", bus.out_inst); end
  endtask

  task automatic test_reset_mid_miss();
    bus.in_pc_ena = 1'b1; bus.in_pc_addr = 32'h0000_0060;
    tick();
    bus.in_pc_ena = 1'b0; rst = 1'b0;
    tick();
    asserts++; if (bus.out_mem_ena !== 1'b0 || bus.out_inst !== 32'h0) begin fails++; $display("FAIL mid_reset got mem=%0h inst=%h exp 0 0", bus.out_mem_ena, bus.out_inst); end
    rst = 1'b1;
    bus.in_pc_ena = 1'b1; bus.in_pc_addr = 32'h0000_0010;
    tick();
    bus.in_pc_ena = 1'b0;
    asserts++; if (bus.out_mem_ena !== 1'b1 || bus.out_inst_ok !== 1'b0) begin fails++; $display("FAIL reset_invalidates got mem=%0h ok=%0h exp 1 0", bus.out_mem_ena, bus.out_inst_ok); end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_back_to_back();
    test_conflict();
    test_rollback_miss();
    test_rollback_fill();
    test_ena();
    test_reset_mid_miss();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule

// File: doc/icache.md
# icache

Direct-mapped, one-word-per-line instruction cache between the instruction fetcher and the memory controller's fetcher port. It is the initiator on that port: on a miss it issues a single-cycle fetch request and waits for the controller's completion pulse. It answers hits in one cycle, and drops its outstanding fetch on misbranch rollback.

## Interface
- INDEX_BITS, 8, log2 of line count (256 lines × 32-bit word; tag = addr[31:INDEX_BITS+2])
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous reset, active-low (low at posedge → reset)
- ena  input  1  global enable; low freezes request acceptance
- in_rollback  input  1  misbranch flush
- in_pc_ena  input  1  fetcher request strobe (one cycle)
- in_pc_addr  input  32  instruction address, word-aligned (bits [1:0] ignored)
- out_inst_ok  output  1  one-cycle pulse, out_inst valid
- out_inst  output  32  instruction word
- out_mem_ena  output  1  one-cycle fetch request to memory controller
- out_mem_addr  output  32  fetch address, word-aligned
- in_mem_ok  input  1  controller completion pulse
- in_mem_data  input  32  fetched word, valid only while in_mem_ok high

## Operation
- Storage: valid[2^INDEX_BITS], tag[], data[]; index = addr[INDEX_BITS+1:2].
- States: IDLE, MISS.
- Reset (rst low): all valid bits 0, state IDLE, out_inst_ok 0, out_mem_ena 0, out_inst 0, out_mem_addr 0.
- out_inst_ok and out_mem_ena default to 0 every cycle; both are pure pulses.
- IDLE, ena high, in_pc_ena high:
  - Hit (valid & tag match): out_inst ← data[index], out_inst_ok ← 1; stay IDLE.
  - Miss: out_mem_addr ← {addr[31:2],2'b00}, out_mem_ena ← 1, latch pending addr; go to MISS.
- MISS: in_pc_ena ignored; the fetcher does not re-request until out_inst_ok.
- MISS with in_mem_ok:
  - Write the line: valid=1, tag/data from pending addr and in_mem_data.
  - out_inst ← in_mem_data, out_inst_ok ← 1; go to IDLE.
- in_rollback high:
  - Takes priority over new requests.
  - Pulses forced 0; state → IDLE; pending request dropped.
  - If state is MISS and in_mem_ok is high in the same cycle, the line is still filled (data is correct) but out_inst_ok stays 0.
  - A request on in_pc_ena in a rollback cycle is discarded.
- ena low: no request accepted; state held. in_mem_ok in MISS is still honoured (fill + ok), so completion is never lost.
- in_mem_ok while IDLE (stray): ignored, no fill.
- Replacement: a fill overwrites the indexed line unconditionally (direct-mapped, no eviction logic).
- No self-modifying-code coherence: stores do not invalidate lines.

## Timing
- Hit latency: request at cycle t → out_inst_ok at t+1.
- Miss: request at t → out_mem_ena at t+1 for exactly one cycle. in_mem_ok at t+k → out_inst_ok at t+k+1.
- Back-to-back hits: a new request is accepted every cycle in IDLE, including the cycle out_inst_ok is high.
- A request in the cycle MISS returns to IDLE (the in_mem_ok cycle) is ignored.
- Reset mid-MISS: state IDLE, valid cleared. The controller is reset by the same rst, so no late in_mem_ok is expected.
- Rollback and out_mem_ena asserted together (edge t+1 for request t, rollback at t+1): the controller also drops the fetch, and icache returns to IDLE.

## Test plan
- Cold miss: reset, request 0x00000010; expect out_mem_ena=1 with addr 0x10 one cycle later; drive in_mem_ok with 0x00A00093 three cycles after that; expect out_inst_ok and out_inst=0x00A00093 the next cycle.
- Hit after fill: request 0x10 again → out_inst_ok at t+1 with 0x00A00093, no out_mem_ena.
- Conflict: INDEX_BITS=8; fill 0x10, then request 0x410 (same index, different tag) → miss; after fill, 0x10 misses again.
- Rollback during MISS: miss on 0x20, assert in_rollback before in_mem_ok → no out_inst_ok, state IDLE; next request 0x20 misses again.
- Rollback coincident with in_mem_ok (data 0x12345678) on 0x30 → no out_inst_ok; a later request 0x30 hits with 0x12345678.
- ena low: request while ena=0 → no response. In MISS, deassert ena and deliver in_mem_ok → out_inst_ok still pulses.
